// File: rtl/lsc_pkg.sv
// Shared mode codes, FSM state encoding and default thresholds for the life-support controller.
package lsc_pkg;

    localparam logic [3:0] MODE_CRUISE = 4'b0000;
    localparam logic [3:0] MODE_DEF    = 4'b0100;
    localparam logic [3:0] MODE_STH    = 4'b1000;

    typedef enum logic [2:0] {
        StCruise  = 3'd0,
        StDefend  = 3'd1,
        StStealth = 3'd2,
        StAutoDef = 3'd3,
        StSafe    = 3'd4
    } lsc_state_e;

    localparam int unsigned DEF_WIDTH      = 32;
    localparam int unsigned DEF_O2_LOW     = 10;
    localparam int unsigned DEF_O2_FULL    = 100;
    localparam int unsigned DEF_PWR_LOW    = 10;
    localparam int unsigned DEF_PWR_FULL   = 100;
    localparam int unsigned DEF_SHIELD_LOW = 20;
    localparam int unsigned DEF_SHIELD_OK  = 50;
    localparam int unsigned DEF_TEMP_HI    = 90;
    localparam int unsigned DEF_COOLDOWN   = 8;
    localparam int unsigned DEF_FATAL_CNT  = 3;

    // Mode code presented to the life-support block for a given controller state.
    function automatic logic [3:0] state_mode(lsc_state_e s);
        case (s)
            StDefend, StAutoDef: return MODE_DEF;
            StStealth:           return MODE_STH;
            default:             return MODE_CRUISE;
        endcase
    endfunction

endpackage

// File: rtl/resupply_timer.sv
// Threshold-triggered one-cycle resupply pulse with a saturating cooldown counter.
module resupply_timer
    import lsc_pkg::*;
#(
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned THRESHOLD = DEF_O2_LOW,
    parameter int unsigned COOLDOWN  = DEF_COOLDOWN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] level,
    output logic             pulse
);

    localparam int unsigned    CW      = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic [WIDTH-1:0] THR   = WIDTH'(THRESHOLD);
    localparam logic [CW-1:0]  CD_LOAD = CW'(COOLDOWN);

    logic [CW-1:0] cd_q, cd_d;
    logic          fire;
    logic          pulse_q;

    always_comb begin
        fire = (level <= THR) && (cd_q == '0);
        cd_d = cd_q;
        if (fire) begin
            cd_d = CD_LOAD;
        end else if (cd_q != '0) begin
            cd_d = cd_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cd_q    <= '0;
            pulse_q <= 1'b0;
        end else begin
            cd_q    <= cd_d;
            pulse_q <= fire;
        end
    end

    assign pulse = pulse_q;

endmodule

// File: rtl/life_support_ctrl.sv
// Command-side life-support controller: crew mode handshake, auto-defence, stealth abort,
// fatal latch into SAFE, and independent o2/power resupply pulses.
module life_support_ctrl
    import lsc_pkg::*;
#(
    parameter int unsigned n          = DEF_WIDTH,
    parameter int unsigned O2_LOW     = DEF_O2_LOW,
    parameter int unsigned O2_FULL    = DEF_O2_FULL,
    parameter int unsigned PWR_LOW    = DEF_PWR_LOW,
    parameter int unsigned PWR_FULL   = DEF_PWR_FULL,
    parameter int unsigned SHIELD_LOW = DEF_SHIELD_LOW,
    parameter int unsigned SHIELD_OK  = DEF_SHIELD_OK,
    parameter int unsigned TEMP_HI    = DEF_TEMP_HI,
    parameter int unsigned COOLDOWN   = DEF_COOLDOWN,
    parameter int unsigned FATAL_CNT  = DEF_FATAL_CNT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [n-1:0] shield_in,
    input  logic [n-1:0] temp_in,
    input  logic [n-1:0] power_in,
    input  logic [n-1:0] o2_in,
    input  logic         fatal_in,
    input  logic         cmd_valid,
    input  logic [3:0]   cmd_mode,
    output logic         cmd_ready,
    output logic         cmd_err,
    output logic [3:0]   mode,
    output logic         chrg,
    output logic [n-1:0] pwr_load,
    output logic         o2sup,
    output logic [n-1:0] o2_load,
    output logic         alarm,
    output logic [2:0]   state
);

    localparam int unsigned FW = (FATAL_CNT > 0) ? $clog2(FATAL_CNT + 1) : 1;
    localparam logic [FW-1:0] FATAL_MAX = FW'(FATAL_CNT);

    lsc_state_e    state_q, state_d, ret_q, ret_d, cmd_state;
    logic [FW-1:0] fatal_cnt_q, fatal_cnt_d;
    logic [3:0]    mode_q;
    logic          ready_q, err_q;
    logic          hot, shield_low, shield_ok;
    logic          cmd_known, cmd_bad, cmd_fire, cmd_take;

    assign hot        = temp_in >= n'(TEMP_HI);
    assign shield_low = shield_in < n'(SHIELD_LOW);
    assign shield_ok  = shield_in >= n'(SHIELD_OK);

    always_comb begin
        fatal_cnt_d = '0;
        if (fatal_in) begin
            fatal_cnt_d = (fatal_cnt_q == FATAL_MAX) ? fatal_cnt_q : fatal_cnt_q + FW'(1);
        end

        cmd_state = StCruise;
        cmd_known = 1'b1;
        case (cmd_mode)
            MODE_CRUISE: cmd_state = StCruise;
            MODE_DEF:    cmd_state = StDefend;
            MODE_STH:    cmd_state = StStealth;
            default:     cmd_known = 1'b0;
        endcase

        cmd_fire = cmd_valid & ready_q;
        cmd_bad  = !cmd_known || (cmd_state == StStealth && hot);
        cmd_take = cmd_fire & !cmd_bad;

        state_d = state_q;
        ret_d   = ret_q;
        // Priority chain; a handshake that loses to a higher event is still consumed.
        if (state_q == StSafe || fatal_cnt_d == FATAL_MAX) begin
            state_d = StSafe;
        end else if (state_q == StStealth && hot) begin
            state_d = StCruise;
        end else if ((state_q == StCruise || state_q == StStealth) && shield_low) begin
            state_d = StAutoDef;
            ret_d   = state_q;
        end else if (state_q == StAutoDef && shield_ok) begin
            state_d = (ret_q == StStealth && hot) ? StCruise : ret_q;
        end else if (cmd_take) begin
            if (state_q == StAutoDef) begin
                ret_d = cmd_state;
            end else begin
                state_d = cmd_state;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StCruise;
            ret_q       <= StCruise;
            fatal_cnt_q <= '0;
            mode_q      <= MODE_CRUISE;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ret_q       <= ret_d;
            fatal_cnt_q <= fatal_cnt_d;
            mode_q      <= state_mode(state_d);
            ready_q     <= (state_d != StSafe);
            err_q       <= cmd_fire & cmd_bad;
        end
    end

    resupply_timer #(
        .WIDTH     (n),
        .THRESHOLD (O2_LOW),
        .COOLDOWN  (COOLDOWN)
    ) u_o2_timer (
        .clk   (clk),
        .rst   (rst),
        .level (o2_in),
        .pulse (o2sup)
    );

    resupply_timer #(
        .WIDTH     (n),
        .THRESHOLD (PWR_LOW),
        .COOLDOWN  (COOLDOWN)
    ) u_pwr_timer (
        .clk   (clk),
        .rst   (rst),
        .level (power_in),
        .pulse (chrg)
    );

    assign cmd_ready = ready_q;
    assign cmd_err   = err_q;
    assign mode      = mode_q;
    assign state     = state_q;
    assign alarm     = (state_q == StSafe);
    assign pwr_load  = n'(PWR_FULL);
    assign o2_load   = n'(O2_FULL);

endmodule

// File: doc/life_support_ctrl.md
Name: life_support_ctrl

Overview:
Command-side controller that drives the life-support block's inputs: mode, chrg/pwr, o2sup/o2. It closes the loop on that block's status outputs (shield, temp, power, o2, fatal).
- Accepts crew mode requests over a valid/ready handshake.
- Issues one-cycle resupply pulses with cooldown.
- Auto-engages defence on low shield.
- Aborts stealth on over-temperature.
- Latches a safe state on sustained fatal.

Parameters:
n, 32, datapath width of status/load values
O2_LOW, 10, o2 level at/below which resupply fires
O2_FULL, 100, value driven on o2_load
PWR_LOW, 10, power level at/below which recharge fires
PWR_FULL, 100, value driven on pwr_load
SHIELD_LOW, 20, shield below this forces auto-defence
SHIELD_OK, 50, shield at/above this releases auto-defence
TEMP_HI, 90, temp at/above this aborts/blocks stealth
COOLDOWN, 8, cycles after a resupply pulse before the next may fire
FATAL_CNT, 3, consecutive fatal cycles that latch SAFE

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
shield_in  input  n  shield status from life support
temp_in  input  n  temperature status
power_in  input  n  power status
o2_in  input  n  oxygen status
fatal_in  input  1  fatal flag from life support
cmd_valid  input  1  crew mode request valid
cmd_mode  input  4  requested mode code
cmd_ready  output  1  controller accepts request this cycle
cmd_err  output  1  one-cycle pulse: request rejected
mode  output  4  mode code to life support
chrg  output  1  one-cycle recharge pulse
pwr_load  output  n  recharge value (PWR_FULL)
o2sup  output  1  one-cycle oxygen resupply pulse
o2_load  output  n  resupply value (O2_FULL)
alarm  output  1  high while in SAFE
state  output  3  FSM state for telemetry

Behaviour:
Reset (rst=0, async):
- state=CRUISE, mode=0000, chrg=0, o2sup=0, cmd_err=0, alarm=0, cmd_ready=0.
- Counters cleared; ret_mode=CRUISE.
- pwr_load/o2_load are constant PWR_FULL/O2_FULL.
- cmd_ready=1 from the first clock after release, except in SAFE.

Mode codes: CRUISE=0000, DEFEND=0100, STEALTH=1000. Any other cmd_mode is rejected.

States: CRUISE, DEFEND, STEALTH, AUTO_DEF, SAFE. The mode output is registered from the next state, so it changes in the cycle after the decision.

Transition priority, evaluated each cycle, highest first:
1. Fatal latch:
   - fatal_cnt increments while fatal_in=1 and clears when fatal_in=0.
   - When it reaches FATAL_CNT -> SAFE.
   - SAFE: mode=0000, alarm=1, cmd_ready=0; exit only by reset.
2. Stealth abort:
   - In STEALTH with temp_in >= TEMP_HI -> CRUISE.
3. Auto-defence entry:
   - In CRUISE or STEALTH with shield_in < SHIELD_LOW -> AUTO_DEF.
   - ret_mode is set to the current state's mode.
4. Auto-defence exit:
   - In AUTO_DEF with shield_in >= SHIELD_OK -> ret_mode.
   - If ret_mode=STEALTH and temp_in >= TEMP_HI, go to CRUISE instead.
5. Command:
   - Handshake fires when cmd_valid & cmd_ready; the transition takes effect next cycle.
   - In AUTO_DEF, a valid command updates ret_mode only; state stays AUTO_DEF.
   - STEALTH is rejected (cmd_err) while temp_in >= TEMP_HI.
   - Invalid codes are rejected (cmd_err); state is unchanged.
   - An accepted command in the same cycle as a higher-priority event is consumed, and the higher-priority event wins.

Resupply (independent of state; runs in SAFE too):
- o2 path: when o2_in <= O2_LOW and o2_cd=0, o2sup=1 for exactly one cycle (next cycle) and o2_cd loads COOLDOWN.
- o2_cd decrements to 0 and saturates there.
- Power path: identical, using power_in, PWR_LOW, pwr_cd, chrg.
- Both pulses may fire in the same cycle.
- Cooldown counter width is clog2(COOLDOWN+1).

Arithmetic: all compares are unsigned n-bit; no wrap.

Decomposition:
- Package lsc_pkg holds:
  - mode codes MODE_CRUISE/MODE_DEF/MODE_STH;
  - state encoding (3-bit constants);
  - default thresholds.
- Sub-module resupply_timer implements threshold compare, cooldown counter and one-cycle pulse.
  - Parameterised by width, threshold and cooldown.
  - Instantiated twice (o2, power).
- The FSM, fatal debounce and handshake stay in the top.

Test Plan:
1. Reset then cmd_valid=1, cmd_mode=0100, shield_in=100, temp_in=0 -> handshake at t, mode=0100 at t+1, state=DEFEND, cmd_err=0.
2. Cruise, then cmd_mode=1000 accepted; raise temp_in to 90 -> mode returns to 0000 one cycle after temp_in=90. A new 1000 request gives a cmd_err pulse and mode stays 0000.
3. o2_in=10 held for 20 cycles, COOLDOWN=8 -> o2sup pulses every 9 cycles (pulse, then 8 idle), o2_load=100. With power_in=5 also held, chrg pulses coincide with o2sup pulses.
4. Stealth with shield_in=15 -> AUTO_DEF, mode=0100. cmd_mode=0000 accepted mid-AUTO_DEF, mode stays 0100. shield_in=50 -> mode=0000 next cycle.
5. fatal_in high 2 cycles, low 1, high 3 -> SAFE entered only after the third consecutive high. alarm=1, cmd_ready=0, mode=0000, o2sup still pulses when o2_in=0. Asserting rst=0 mid-SAFE immediately clears alarm and returns to CRUISE.
6. cmd_mode=0011 -> cmd_err single-cycle pulse, state unchanged.
